// File: rtl/sca_trace_sequencer.sv
// sca_trace_sequencer: shifts a config word into a serial receiver, settles, then emits a counted flip_clk burst with scope trigger.
module sca_trace_sequencer #(
  parameter int CFG_LEN    = 16,
  parameter int SETTLE_CYC = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [CFG_LEN-1:0] cfg_word,
  input  logic [7:0]         toggle_count,
  input  logic [7:0]         half_period,
  output logic               ser_clk,
  output logic               ser_data,
  output logic               flip_clk,
  output logic               trigger,
  output logic               busy,
  output logic               done
);
  localparam int IW = (CFG_LEN > 1) ? $clog2(CFG_LEN) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, TOGGLE, DONE} state_t;
  state_t             state, state_n;
  logic [CFG_LEN-1:0] cfg_q, cfg_n;
  logic [7:0]         tc_q, tc_n, hp_q, hp_n, cnt, cnt_n;
  logic [IW-1:0]      bit_idx, bit_n;
  logic               phase, phase_n;
  logic [8:0]         edges, edges_n;
  logic               ser_clk_n, ser_data_n, flip_n, trigger_n, done_n;
  // State, captured run parameters and registered outputs; outputs are loaded with the values of the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cfg_q    <= '0;
      tc_q     <= '0;
      hp_q     <= '0;
      cnt      <= '0;
      bit_idx  <= '0;
      phase    <= 1'b0;
      edges    <= '0;
      ser_clk  <= 1'b0;
      ser_data <= 1'b0;
      flip_clk <= 1'b0;
      trigger  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cfg_q    <= cfg_n;
      tc_q     <= tc_n;
      hp_q     <= hp_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_n;
      phase    <= phase_n;
      edges    <= edges_n;
      ser_clk  <= ser_clk_n;
      ser_data <= ser_data_n;
      flip_clk <= flip_n;
      trigger  <= trigger_n;
      busy     <= state_n != IDLE;
      done     <= done_n;
    end
  end
  // Next state and next output values; abort overrides every transition, all outputs default low.
  always_comb begin
    state_n    = state;
    cfg_n      = cfg_q;
    tc_n       = tc_q;
    hp_n       = hp_q;
    cnt_n      = cnt;
    bit_n      = bit_idx;
    phase_n    = phase;
    edges_n    = edges;
    ser_clk_n  = 1'b0;
    ser_data_n = 1'b0;
    flip_n     = 1'b0;
    trigger_n  = 1'b0;
    done_n     = 1'b0;
    if (state != IDLE && abort) state_n = IDLE;
    else begin
      case (state)
        IDLE: if (start) begin
          state_n    = LOAD;
          cfg_n      = cfg_word;
          tc_n       = toggle_count;
          hp_n       = half_period;
          bit_n      = '0;
          phase_n    = 1'b0;
          ser_clk_n  = 1'b1;
          ser_data_n = cfg_word[CFG_LEN-1];
        end
        LOAD: if (!phase) begin
          phase_n    = 1'b1;
          ser_data_n = cfg_q[CFG_LEN-1];
        end else if (bit_idx == IW'(CFG_LEN-1)) begin
          state_n = SETTLE;
          cnt_n   = '0;
        end else begin
          phase_n    = 1'b0;
          bit_n      = bit_idx + 1'b1;
          cfg_n      = {cfg_q[CFG_LEN-2:0], 1'b0};
          ser_clk_n  = 1'b1;
          ser_data_n = cfg_q[CFG_LEN-2];
        end
        SETTLE: if (cnt == 8'(SETTLE_CYC-1)) begin
          cnt_n     = '0;
          edges_n   = '0;
          state_n   = (tc_q == 8'd0) ? DONE : TOGGLE;
          done_n    = tc_q == 8'd0;
          trigger_n = tc_q != 8'd0;
        end else cnt_n = cnt + 8'd1;
        TOGGLE: if (cnt == hp_q) begin
          cnt_n   = '0;
          edges_n = edges + 9'd1;
          if (edges + 9'd1 == {tc_q, 1'b0}) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            trigger_n = 1'b1;
            flip_n    = ~flip_clk;
          end
        end else begin
          cnt_n     = cnt + 8'd1;
          trigger_n = 1'b1;
          flip_n    = flip_clk;
        end
        DONE: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// File: doc/sca_trace_sequencer.md
SCA_TRACE_SEQUENCER -- requirements
Module: sca_trace_sequencer

Interface
REQ-001 SHALL have parameter CFG_LEN, default 16: number of configuration bits shifted into the downstream serial receiver (2 x DUT input count).
REQ-002 SHALL have parameter SETTLE_CYC, default 4: clk cycles waited between end of load and first flip_clk edge; legal range 1..255.
REQ-003 SHALL have port clk  input  1: system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1: one-cycle request to run one load+toggle sequence.
REQ-006 SHALL have port abort  input  1: synchronous abort of a running sequence.
REQ-007 SHALL have port cfg_word  input  CFG_LEN: configuration word to shift out; bit k lands in receiver stage k.
REQ-008 SHALL have port toggle_count  input  8: number of full flip_clk periods to generate.
REQ-009 SHALL have port half_period  input  8: flip_clk half-period minus one, in clk cycles.
REQ-010 SHALL have port ser_clk  output  1: serial clock to receiver; receiver shifts on its falling edge.
REQ-011 SHALL have port ser_data  output  1: serial data to receiver.
REQ-012 SHALL have port flip_clk  output  1: toggle stimulus to DUT inputs.
REQ-013 SHALL have port trigger  output  1: scope trigger, high throughout TOGGLE.
REQ-014 SHALL have port busy  output  1: high in every state except IDLE.
REQ-015 SHALL have port done  output  1: one-cycle completion pulse.

Function
REQ-016 SHALL implement states IDLE, LOAD, SETTLE, TOGGLE, DONE; all outputs registered.
REQ-017 SHALL, in IDLE with start=1, capture cfg_word, toggle_count, half_period into internal registers and enter LOAD next cycle; input changes afterwards have no effect on the run.
REQ-018 SHALL ignore start whenever busy=1.
REQ-019 SHALL in LOAD emit bits MSB first (cfg_word[CFG_LEN-1] first), each bit taking 2 cycles: phase A ser_clk=1, ser_data=bit; phase B ser_clk=0, ser_data held; LOAD lasts exactly 2*CFG_LEN cycles.
REQ-020 SHALL enter SETTLE after phase B of the last bit, hold ser_clk=0, ser_data=0, and stay exactly SETTLE_CYC cycles.
REQ-021 SHALL enter DONE directly from SETTLE when captured toggle_count=0 (trigger never asserts).
REQ-022 SHALL otherwise enter TOGGLE with flip_clk=0, toggling flip_clk every half_period+1 cycles, for 2*toggle_count edges, ending with flip_clk=0.
REQ-023 SHALL size the edge counter at 9 bits so toggle_count=255 yields 510 edges without wrap.
REQ-024 SHALL assert trigger on the first TOGGLE cycle and deassert on the cycle after the last falling edge of flip_clk, entering DONE.
REQ-025 SHALL assert done for exactly one cycle in DONE, then return to IDLE; a start in the DONE cycle is ignored.
REQ-026 SHALL on abort=1 in any non-IDLE state go to IDLE next cycle with ser_clk=0, ser_data=0, flip_clk=0, trigger=0, no done pulse; abort takes priority over all other transitions.
REQ-027 SHALL keep ser_clk=0 and ser_data=0 in every state other than LOAD.

Reset
REQ-028 SHALL on reset=0 immediately force state IDLE and ser_clk, ser_data, flip_clk, trigger, busy, done all 0, including mid-LOAD or mid-TOGGLE.
REQ-029 SHALL clear all captured registers and counters on reset; first start after reset release behaves as from power-up.

Verification
REQ-030 CFG_LEN=4, cfg_word=4'b1010, toggle_count=0 -> ser_data sequence 1,0,1,0 over 8 cycles, 4 ser_clk falling edges, model receiver = 4'b1010, done 8+SETTLE_CYC+1 cycles after start capture, trigger never high.
REQ-031 toggle_count=3, half_period=1 -> flip_clk 0,0,1,1 repeated 3 times (12 cycles), trigger high 12 cycles, flip_clk ends 0, then done pulse.
REQ-032 toggle_count=255, half_period=0 -> exactly 510 flip_clk edges, no counter wrap, single done.
REQ-033 start pulsed again mid-LOAD and mid-TOGGLE -> ignored, single sequence, cfg_word change mid-run has no effect on ser_data.
REQ-034 abort during TOGGLE -> next cycle IDLE, flip_clk=0, trigger=0, busy=0, no done; subsequent start runs normally.
REQ-035 reset asserted mid-LOAD -> all outputs 0 asynchronously; after release start produces complete correct load.
